mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- Next-generation MIPS MEM stage: replaces the pure pass-through with a load/store unit plus a registered MEM/WB pipeline register.
- Formats store data and byte enables, and drives a req/ack data-memory port.
- Aligns and sign/zero-extends load data; stalls the upstream pipeline while memory is busy.
- Sits between the EX/MEM register and WB/regfile.

Parameters:
- ADDR_WIDTH, 32, data-memory byte address width.
- REG_ADDR_WIDTH, 5, register-file address width.
- TIMEOUT_CYCLES, 16, max WAIT cycles before bus-error abort (≥1).
- DATA_WIDTH: fixed 32 as a package constant, not a parameter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  EX/MEM slot holds a valid instruction
- ex_w_reg_addr  in  REG_ADDR_WIDTH  destination register
- ex_w_reg_data  in  32  ALU result (non-memory ops)
- ex_w_reg_en  in  1  register write enable from decode
- ex_mem_op  in  4  memory op code (package enum)
- ex_mem_addr  in  ADDR_WIDTH  effective address
- ex_mem_wdata  in  32  store source data (unformatted)
- stall_req  out  1  hold EX/MEM inputs stable
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits 0)
- dmem_be  out  4  byte enables, little-endian lanes
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  one-cycle completion
- dmem_rdata  in  32  read data, valid with ack
- wb_valid  out  1  MEM/WB slot valid
- wb_w_reg_addr  out  REG_ADDR_WIDTH
- wb_w_reg_data  out  32
- wb_w_reg_en  out  1
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Clock and reset: one clock, clk; reset rst, synchronous, active-high. Reset drives every output to 0, state to IDLE and the timeout counter to 0.
- Op codes: NONE=0, LB, LBU, LH, LHU, LW, SB, SH, SW.
- States: IDLE and WAIT.
- IDLE, ex_valid=1, op NONE:
  - Next edge: wb_* <= ex_* and wb_valid <= 1 (latency 1).
  - stall_req=0.
- IDLE, ex_valid=0:
  - Next edge: wb_valid <= 0 and wb_w_reg_en <= 0.
- IDLE, ex_valid=1, memory op:
  - stall_req=1 combinationally in this cycle.
  - Next edge: capture dest, op and addr low bits; drive dmem_req=1 with addr/we/be/wdata; counter <= 0; go to WAIT.
  - Next edge also: wb_valid <= 0 (bubble).
- WAIT:
  - dmem_* held stable; ex_* ignored.
  - stall_req = !dmem_ack.
- WAIT with dmem_ack=1:
  - Next edge: dmem_req <= 0, state <= IDLE, wb_valid <= 1.
  - Load: wb_w_reg_en <= captured en, wb_w_reg_data <= extended lane.
  - Store: wb_w_reg_en <= 0.
  - Upstream advances on the ack cycle.
- WAIT without ack: counter++.
- Timeout, counter == TIMEOUT_CYCLES-1 without ack:
  - Next edge: dmem_req <= 0, bus_err <= 1 for one cycle, wb_valid <= 1, wb_w_reg_en <= 0, state <= IDLE.
  - stall_req=0 in that final cycle.
- Ack coinciding with timeout: ack wins, no bus_err.
- Ack in IDLE: ignored. This covers a late ack after timeout or after reset.
- Reset mid-WAIT: dmem_req drops at that edge; the transaction is abandoned.
- Store formatting:
  - SB: be = 1<<addr[1:0]; wdata = byte replicated ×4.
  - SH: be = addr[1] ? 1100 : 0011; wdata = halfword replicated ×2.
  - SW: be = 1111.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Register 0: if dest = 0, wb_w_reg_en is forced to 0.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Misaligned accesses are halfword with addr[0]=1, or word with addr[1:0]≠0.
  - A misaligned access issues no request and takes no WAIT; the next edge gives wb_valid=1, wb_w_reg_en=0.
  - Extra output align_err (1 bit) pulses for one cycle; stall_req stays 0.
- Undefined:
  - No align_err port.
  - Offending low address bits are ignored: word forced aligned; halfword uses addr[1].

Decomposition:
- Package mem_pkg:
  - DATA_WIDTH=32.
  - mem_op_t enum plus is_load/is_store/size helper functions.
  - lsu_state_t {IDLE, WAIT}.
- Sub-module mem_lane_align, purely combinational:
  - Store: op + addr[1:0] + wdata -> be, formatted wdata.
  - Load: op + addr[1:0] + rdata -> extended load data.

Test Plan:
- NONE op, ex_w_reg_addr=3, data=0x1234, en=1 -> next cycle wb_valid=1, wb data=0x1234, stall_req never high.
- LB, addr=0x...02, ack 3 cycles after req, rdata=0x0080_0000 -> dmem_addr low bits 00; stall_req high 4 cycles; wb data=0xFFFF_FF80; LBU on the same data gives 0x0000_0080.
- SH, addr=0x...02, wdata=0xAAAA_BEEF -> be=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1; after ack wb_valid=1, wb_w_reg_en=0.
- LW with no ack, TIMEOUT_CYCLES=16 -> dmem_req high 16 cycles then drops; bus_err one pulse; wb_w_reg_en=0; an ack 2 cycles later is ignored.
- Assert rst during WAIT -> next edge all outputs 0, state IDLE; a following NONE op completes with latency 1.
- With MEM_ALIGN_CHECK_EN, LW addr=0x...01 -> no dmem_req, align_err pulse, wb_w_reg_en=0; without the macro -> dmem_addr=0x...00, normal load.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage load/store unit: op codes, access sizes,
// FSM states and small op-classification helpers.
package mem_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } mem_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic mem_size_t op_size(input logic [3:0] op);
        mem_size_t sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            OP_LW, OP_SW:         sz = SZ_WORD;
            default:              sz = SZ_NONE;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        mem_size_t sz;
        sz = op_size(op);
        return ((sz == SZ_HALF) && lo[0]) || ((sz == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables / lane-replicated data,
// and load lane extraction with sign or zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [3:0]  i_st_op,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_wdata,
    input  logic [3:0]  i_ld_op,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_st_wdata;
        case (op_size(i_st_op))
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_st_addr_lo;
                o_wdata = {4{i_st_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_st_wdata[15:0]}};
            end
            SZ_WORD: o_be = 4'b1111;
            default: o_be = 4'b0000;
        endcase
    end

    // Halfword lane uses addr[1] only; addr[0] is dropped for unaligned halves.
    assign w_byte = i_ld_rdata[{i_ld_addr_lo, 3'b000} +: 8];
    assign w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_op)
            OP_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_ld_data = {24'd0, w_byte};
            OP_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MIPS MEM stage: load/store unit with req/ack data-memory port, timeout abort
// and registered MEM/WB slot. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    input  logic [REG_ADDR_WIDTH-1:0] ex_w_reg_addr,
    input  logic [DATA_WIDTH-1:0]     ex_w_reg_data,
    input  logic                      ex_w_reg_en,
    input  logic [3:0]                ex_mem_op,
    input  logic [ADDR_WIDTH-1:0]     ex_mem_addr,
    input  logic [DATA_WIDTH-1:0]     ex_mem_wdata,
    output logic                      stall_req,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [ADDR_WIDTH-1:0]     dmem_addr,
    output logic [3:0]                dmem_be,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    input  logic                      dmem_ack,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_w_reg_addr,
    output logic [DATA_WIDTH-1:0]     wb_w_reg_data,
    output logic                      wb_w_reg_en,
    output logic                      bus_err
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                      align_err
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_t                r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [3:0]                r_op;
    logic [1:0]                r_addr_lo;
    logic [REG_ADDR_WIDTH-1:0] r_dest;
    logic                      r_en;

    logic                      w_is_ld;
    logic                      w_is_st;
    logic                      w_misalign;
    logic                      w_start;
    logic                      w_last;
    logic [3:0]                w_be;
    logic [DATA_WIDTH-1:0]     w_st_wdata;
    logic [DATA_WIDTH-1:0]     w_ld_data;

    assign w_is_ld = is_load(ex_mem_op);
    assign w_is_st = is_store(ex_mem_op);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ex_valid && is_misaligned(ex_mem_op, ex_mem_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start = ex_valid && (w_is_ld || w_is_st) && !w_misalign;
    assign w_last  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Upstream is released on the ack cycle and on the final timeout cycle.
    always_comb begin
        stall_req = 1'b0;
        if (r_state == IDLE)
            stall_req = w_start;
        else
            stall_req = !dmem_ack && !w_last;
    end

    mem_lane_align u_lane (
        .i_st_op      (ex_mem_op),
        .i_st_addr_lo (ex_mem_addr[1:0]),
        .i_st_wdata   (ex_mem_wdata),
        .i_ld_op      (r_op),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_rdata   (dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_st_wdata),
        .o_ld_data    (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_op          <= 4'd0;
            r_addr_lo     <= 2'd0;
            r_dest        <= '0;
            r_en          <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_be       <= 4'd0;
            dmem_wdata    <= '0;
            wb_valid      <= 1'b0;
            wb_w_reg_addr <= '0;
            wb_w_reg_data <= '0;
            wb_w_reg_en   <= 1'b0;
            bus_err       <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            align_err     <= 1'b0;
`endif
        end else begin
            bus_err <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            align_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!ex_valid) begin
                        wb_valid    <= 1'b0;
                        wb_w_reg_en <= 1'b0;
                    end else if (w_misalign) begin
                        wb_valid      <= 1'b1;
                        wb_w_reg_addr <= ex_w_reg_addr;
                        wb_w_reg_en   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                        align_err     <= 1'b1;
`endif
                    end else if (w_start) begin
                        r_op       <= ex_mem_op;
                        r_addr_lo  <= ex_mem_addr[1:0];
                        r_dest     <= ex_w_reg_addr;
                        r_en       <= ex_w_reg_en;
                        r_cnt      <= '0;
                        r_state    <= WAIT;
                        dmem_req   <= 1'b1;
                        dmem_we    <= w_is_st;
                        dmem_addr  <= {ex_mem_addr[ADDR_WIDTH-1:2], 2'b00};
                        dmem_be    <= w_be;
                        dmem_wdata <= w_st_wdata;
                        wb_valid    <= 1'b0;
                        wb_w_reg_en <= 1'b0;
                    end else begin
                        wb_valid      <= 1'b1;
                        wb_w_reg_addr <= ex_w_reg_addr;
                        wb_w_reg_data <= ex_w_reg_data;
                        wb_w_reg_en   <= ex_w_reg_en && (ex_w_reg_addr != '0);
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        dmem_req      <= 1'b0;
                        r_state       <= IDLE;
                        wb_valid      <= 1'b1;
                        wb_w_reg_addr <= r_dest;
                        if (is_load(r_op)) begin
                            wb_w_reg_data <= w_ld_data;
                            wb_w_reg_en   <= r_en && (r_dest != '0);
                        end else begin
                            wb_w_reg_en   <= 1'b0;
                        end
                    end else if (w_last) begin
                        dmem_req      <= 1'b0;
                        bus_err       <= 1'b1;
                        r_state       <= IDLE;
                        wb_valid      <= 1'b1;
                        wb_w_reg_addr <= r_dest;
                        wb_w_reg_en   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
